// File: rtl/mips_pkg.sv
// Shared MIPS debug-path definitions: register-file geometry and dump FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/dump_out_stage.sv
// Output holding register for the dump stream: captures one {addr, data} word.
// Latency: load -> out_valid on the next clk edge.
// Backpressure: the word is held unchanged until clear (or a new load) is applied.
// Ports: clk, rst_n (sync, active-low); load/load_addr/load_data capture a word;
//        clear drops out_valid; out_valid/out_addr/out_data present the held word.
module dump_out_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  // load wins over clear: a new word replaces the one being handed off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_addr  <= load_addr;
      out_data  <= load_data;
    end else if (clear) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: walks FIRST_REG..LAST_REG on an async register-file read port
// and streams {addr, data} words. Latency: start at edge N -> first word valid after N+1,
// then one word per cycle. Backpressure: out_ready low holds the current word stable.
// Ports: clk, rst_n (sync, active-low); start/busy/done control; rd_addr/rd_data to the
//        register-file read port; out_valid/out_ready/out_addr/out_data word stream.
module regfile_dump_reader
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  dump_state_t       state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic              issued_all, issued_all_d;
  logic              busy_d, done_d;
  logic              ld, clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= FIRST_A;
      issued_all <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      issued_all <= issued_all_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    issued_all_d = issued_all;
    busy_d       = busy;
    done_d       = 1'b0;
    ld           = 1'b0;
    clr          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_d        = FIRST_A;
          issued_all_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        // Refill the holding register when it is empty or being drained this cycle.
        ld = !issued_all && (!out_valid || out_ready);
        if (ld) begin
          // idx stops at LAST_REG; issued_all marks that the final word is out.
          if (idx == LAST_A) issued_all_d = 1'b1;
          else               idx_d        = idx + ADDR_W'(1);
        end else if (out_valid && out_ready) begin
          clr = 1'b1;
        end
        if (issued_all && out_valid && out_ready) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign rd_addr = idx;

  dump_out_stage #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .clear    (clr),
    .load_addr(idx),
    .load_data(rd_data),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: a behavioural MIPS register file (reg 0 reads zero, writes on posedge)
// feeds two dump readers, full range 0..31 and a narrow range 4..6.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, busy, done, out_valid, out_ready;
  logic [4:0]  rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        start1, busy1, done1, out_valid1, out_ready1;
  logic [4:0]  rd_addr1, out_addr1;
  logic [31:0] rd_data1, out_data1;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] regs [32];
  logic [31:0] exp_v [32];

  int checks = 0;
  int errors = 0;

  int       hk_idx [2];
  logic [4:0]  hk_a [2];
  logic [31:0] hk_d [2];
  bit       hk_on [2];

  always #5 clk = ~clk;

  always @(posedge clk) if (we) regs[wa] <= wd;
  assign rd_data  = (rd_addr  == 5'd0) ? 32'd0 : regs[rd_addr];
  assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : regs[rd_addr1];

  regfile_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  regfile_dump_reader #(.FIRST_REG(4), .LAST_REG(6)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_addr(out_addr1), .out_data(out_data1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we = 1'b1; wa = 5'(a); wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_novalid", 32'(out_valid), 32'd0);
  endtask

  // Runs from a negedge with the dump already started, drains nwords words from
  // index first, then checks the done pulse. pct is the out_ready duty in percent.
  task automatic collect(input int nwords, input int pct, input bit b2b, input int first);
    int got = 0;
    int cyc = 0;
    int gaps = 0;
    bit held = 0;
    bit rdy;
    logic [4:0]  ha;
    logic [31:0] hd;
    while (got < nwords && cyc < 400) begin
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_addr", 32'(out_addr), 32'(ha));
        chk("hold_data", out_data, hd);
      end
      chk("done_early", 32'(done), 32'd0);
      we = 1'b0;
      for (int h = 0; h < 2; h++) begin
        if (hk_on[h] && int'(rd_addr) == hk_idx[h]) begin
          we = 1'b1; wa = hk_a[h]; wd = hk_d[h];
          hk_on[h] = 0;
        end
      end
      rdy = ($urandom_range(99) < pct);
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk("word_addr", 32'(out_addr), 32'(first + got));
        chk("word_data", out_data, exp_v[first + got]);
        got++;
        held = 0;
      end else if (out_valid) begin
        held = 1; ha = out_addr; hd = out_data;
      end else if (got > 0) begin
        gaps++;
      end
      @(negedge clk);
      cyc++;
    end
    we = 1'b0;
    out_ready = 1'b0;
    chk("word_count", 32'(got), 32'(nwords));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_novalid", 32'(out_valid), 32'd0);
    if (b2b) chk("gaps", 32'(gaps), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int cyc;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; out_ready1 = 1'b0;
    we = 1'b0; wa = '0; wd = '0;
    hk_on[0] = 0; hk_on[1] = 0;
    hk_idx[0] = 0; hk_idx[1] = 0;
    hk_a[0] = '0; hk_a[1] = '0; hk_d[0] = '0; hk_d[1] = '0;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      exp_v[k] = 32'h1111_1111 * 32'(k);
      wr(k, exp_v[k]);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Reset / idle state.
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_rd_addr1", 32'(rd_addr1), 32'd4);

    // 1. Full dump, consumer always ready.
    pulse_start();
    collect(32, 100, 1, 0);

    // 2. Random backpressure.
    pulse_start();
    collect(32, 40, 0, 0);

    // 3. start held through the dump: one dump, restart only from IDLE after done.
    start = 1'b1;
    @(negedge clk);
    chk("held_busy", 32'(busy), 32'd1);
    collect(32, 100, 1, 0);
    chk("idle_after_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    collect(32, 100, 1, 0);

    // 4. Reset while word 12 is presented.
    pulse_start();
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_valid && out_addr == 5'd12) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_12", 32'(out_addr), 32'd12);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rd_addr", 32'(rd_addr), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_quiet", 32'({out_valid, busy, done}), 32'd0);
    end
    out_ready = 1'b0;
    pulse_start();
    collect(32, 100, 1, 0);

    // 5. Write ahead of the read pointer is seen; write behind it is not.
    exp_v[20] = 32'hDEAD_BEEF;
    hk_idx[0] = 10; hk_a[0] = 5'd20; hk_d[0] = 32'hDEAD_BEEF; hk_on[0] = 1;
    hk_idx[1] = 11; hk_a[1] = 5'd5;  hk_d[1] = 32'h0000_CAFE; hk_on[1] = 1;
    pulse_start();
    collect(32, 100, 1, 0);
    exp_v[5] = 32'h0000_CAFE;

    // 6a. Write committing on the sampling edge of word 7: old value captured.
    hk_idx[0] = 7; hk_a[0] = 5'd7; hk_d[0] = 32'h0000_ABCD; hk_on[0] = 1;
    pulse_start();
    collect(32, 100, 1, 0);
    exp_v[7] = 32'h0000_ABCD;
    pulse_start();
    collect(32, 100, 1, 0);

    // 6b. Narrow range 4..6.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n_busy", 32'(busy1), 32'd1);
    chk("n_novalid", 32'(out_valid1), 32'd0);
    out_ready1 = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 20) begin
      chk("n_done_early", 32'(done1), 32'd0);
      if (out_valid1) begin
        chk("n_addr", 32'(out_addr1), 32'(4 + n));
        chk("n_data", out_data1, exp_v[4 + n]);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("n_count", 32'(n), 32'd3);
    chk("n_done", 32'(done1), 32'd1);
    chk("n_done_busy", 32'(busy1), 32'd0);
    chk("n_novalid_end", 32'(out_valid1), 32'd0);
    chk("n_rd_addr_end", 32'(rd_addr1), 32'd6);
    @(negedge clk);
    chk("n_done_clear", 32'(done1), 32'd0);
    out_ready1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
